// File: rtl/costas_pd.sv
// Costas-loop phase discriminator for a despread BPSK stream.
// Integrates I and Q over DUMP_LEN valid samples, then forms the
// decision-directed error sign(I)*Q, halves it, and strobes it out on
// 'load' for the carrier loop filter. The result appears two edges after
// the final sample of each period.
module costas_pd #(
  parameter int DUMP_LEN = 31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sync,
  input  logic               din_valid,
  input  logic signed [15:0] din_i,
  input  logic signed [15:0] din_q,
  output logic signed [22:0] pd,
  output logic               load
);

  localparam logic        [8:0]  LastCnt = 9'(DUMP_LEN);
  localparam logic signed [23:0] MinVal  = 24'sh800000;
  localparam logic signed [23:0] MaxVal  = 24'sh7FFFFF;

  // Integrate-and-dump state
  logic signed [23:0] accI_q, accI_d;
  logic signed [23:0] accQ_q, accQ_d;
  logic        [8:0]  cnt_q, cnt_d;

  // Stage 1: dumped period sums
  logic signed [23:0] dumpI_q, dumpI_d;
  logic signed [23:0] dumpQ_q, dumpQ_d;
  logic               dumpVld_q, dumpVld_d;

  // Stage 2: discriminator term
  logic signed [23:0] term_q, term_d;
  logic               termVld_q, termVld_d;

  // Stage 3: output word and strobe
  logic signed [22:0] pd_q, pd_d;
  logic               load_q, load_d;

  logic signed [23:0] sampleI, sampleQ;
  logic signed [23:0] sumI, sumQ;
  logic        [8:0]  cntInc;

  assign sampleI = {{8{din_i[15]}}, din_i};
  assign sampleQ = {{8{din_q[15]}}, din_q};
  assign sumI    = accI_q + sampleI;
  assign sumQ    = accQ_q + sampleQ;
  assign cntInc  = cnt_q + 9'd1;

  // Accumulate valid samples; dump on the sample that completes a period.
  // Losing lock clears everything, and a code-period sync restarts the
  // period with the coincident sample (if any) as its first sample, which
  // also suppresses a dump that would otherwise happen on that cycle.
  always_comb begin
    accI_d    = accI_q;
    accQ_d    = accQ_q;
    cnt_d     = cnt_q;
    dumpI_d   = dumpI_q;
    dumpQ_d   = dumpQ_q;
    dumpVld_d = 1'b0;
    if (!en) begin
      accI_d = '0;
      accQ_d = '0;
      cnt_d  = '0;
    end else if (sync) begin
      if (din_valid) begin
        accI_d = sampleI;
        accQ_d = sampleQ;
        cnt_d  = 9'd1;
      end else begin
        accI_d = '0;
        accQ_d = '0;
        cnt_d  = '0;
      end
    end else if (din_valid) begin
      if (cntInc == LastCnt) begin
        dumpI_d   = sumI;
        dumpQ_d   = sumQ;
        dumpVld_d = 1'b1;
        accI_d    = '0;
        accQ_d    = '0;
        cnt_d     = '0;
      end else begin
        accI_d = sumI;
        accQ_d = sumQ;
        cnt_d  = cntInc;
      end
    end
  end

  // Discriminator sign(I)*Q; zero I counts as positive and negating the
  // most negative Q saturates instead of wrapping.
  always_comb begin
    term_d = dumpQ_q;
    if (dumpI_q < 24'sd0) begin
      if (dumpQ_q == MinVal) begin
        term_d = MaxVal;
      end else begin
        term_d = -dumpQ_q;
      end
    end
    termVld_d = en & dumpVld_q;
  end

  // Halve the term into the output word; pd holds between strobes and a
  // lock drop discards whatever is still in flight.
  always_comb begin
    pd_d   = pd_q;
    load_d = 1'b0;
    if (en && termVld_q) begin
      pd_d   = 23'(term_q >>> 1);
      load_d = 1'b1;
    end
  end

  // All state registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      accI_q    <= '0;
      accQ_q    <= '0;
      cnt_q     <= '0;
      dumpI_q   <= '0;
      dumpQ_q   <= '0;
      dumpVld_q <= 1'b0;
      term_q    <= '0;
      termVld_q <= 1'b0;
      pd_q      <= '0;
      load_q    <= 1'b0;
    end else begin
      accI_q    <= accI_d;
      accQ_q    <= accQ_d;
      cnt_q     <= cnt_d;
      dumpI_q   <= dumpI_d;
      dumpQ_q   <= dumpQ_d;
      dumpVld_q <= dumpVld_d;
      term_q    <= term_d;
      termVld_q <= termVld_d;
      pd_q      <= pd_d;
      load_q    <= load_d;
    end
  end

  assign pd   = pd_q;
  assign load = load_q;

endmodule

// File: doc/costas_pd.md
COSTAS_PD -- requirements
Module: costas_pd

Interface
REQ-001 SHALL provide parameter DUMP_LEN, default 31: valid samples per integrate-and-dump period; legal range 2..256.
REQ-002 SHALL provide port clk  input  1  FPGA system clock, 49.6 MHz; all logic on rising edge.
REQ-003 SHALL provide port rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL provide port en  input  1  PN-sync lock indication; high = discriminator running.
REQ-005 SHALL provide port sync  input  1  one-cycle code-period-start pulse from the PN sync block.
REQ-006 SHALL provide port din_valid  input  1  qualifies din_i/din_q.
REQ-007 SHALL provide port din_i  input  16  signed despread in-phase sample.
REQ-008 SHALL provide port din_q  input  16  signed despread quadrature sample.
REQ-009 SHALL provide port pd  output  23  signed phase-error word for the carrier loop filter.
REQ-010 SHALL provide port load  output  1  one-cycle strobe; pd is new and valid while high.

Function
REQ-011 SHALL keep two 24-bit signed accumulators, acc_i and acc_q, and a 9-bit valid-sample counter cnt.
REQ-012 On each cycle with en=1 and din_valid=1, acc_i/acc_q SHALL add the sign-extended samples and cnt SHALL increment.
REQ-013 When the sample accepted makes cnt reach DUMP_LEN, the next edge SHALL latch final sums (including that sample) into dump_i/dump_q, clear acc_i/acc_q/cnt, and start a new period.
REQ-014 Discriminator: if dump_i >= 0, term = dump_q; else term = -dump_q; negation of -2^23 SHALL saturate to 2^23-1.
REQ-015 pd SHALL equal term arithmetically shifted right by 1 (term[23:1]), registered.
REQ-016 load SHALL assert exactly one cycle, two clk edges after the edge capturing the final sample of a period, coincident with the new pd.
REQ-017 pd SHALL hold its value between load strobes.
REQ-018 sync=1 SHALL discard any partial accumulation; if din_valid=1 in the same cycle, that sample SHALL become sample 1 of the new period (acc = sample, cnt = 1).
REQ-019 sync coinciding with what would be the final sample SHALL take priority: no dump, no load for that period.
REQ-020 en=0 SHALL clear acc_i, acc_q, cnt and suppress load; an in-flight dump pipeline SHALL be flushed (no load); pd SHALL hold.
REQ-021 Cycles with din_valid=0 SHALL leave accumulators and cnt unchanged.
REQ-022 Accumulators SHALL not overflow for legal DUMP_LEN (256 x 2^15 = 2^23 fits in 24 bits signed).

Reset
REQ-023 rst low SHALL asynchronously clear acc_i, acc_q, dump_i, dump_q, cnt, pipeline valid flags, pd (0) and load (0).
REQ-024 Reset released mid-period SHALL restart from cnt=0; no partial result from before reset SHALL ever appear on pd.
REQ-025 Deassertion of rst SHALL be synchronised externally; first accepted sample is on the first edge with rst high.

Verification
REQ-026 DUMP_LEN=4, en=1, din_i=100, din_q=50 continuous valid -> every 4 samples load pulses once, pd=100, two edges after the 4th sample.
REQ-027 DUMP_LEN=4, din_i=-100, din_q=50 -> pd=-100; din_i=0, din_q=-50 -> pd=-100 (zero treated as positive).
REQ-028 DUMP_LEN=256, din_q=-32768, din_i=-1 -> term saturates, pd=4194303; with din_i=+1 -> pd=-4194304.
REQ-029 DUMP_LEN=4, sync pulse with valid after 2 samples of (100,50) -> no load at old boundary; load 4 valid samples after sync, pd=100.
REQ-030 Gapped din_valid (1 of every 3 cycles) -> pd identical to continuous case; en dropped one cycle before the final sample or during the dump pipeline -> no load, pd unchanged.
REQ-031 rst asserted mid-period and mid-pipeline -> pd=0, load=0 immediately; after release, first load only after DUMP_LEN fresh samples.
